serial_frame_arbiter: RTL

- Shares one serial output line between 4 requesters, framing each granted payload in the receiver's format: start bit 0, 2-bit port id, 4-bit bit-count, then payload bits, all MSB first.
- Round-robin arbitration; after each frame, waits for the downstream `transmitted` acknowledge before granting again.
- Sits upstream of the serial message receiver and drives its `serIn` and `transmitted`-paced flow.

---
 rtl/serial_frame_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_frame_arbiter.sv
// ============================================================================
// Module   : serial_frame_arbiter
// Purpose  : Round-robin arbiter for 4 requesters that frames each granted
//            payload onto one serial line and waits for a downstream acknowledge.
//            Optional macro SERIAL_ARB_ACK_TIMEOUT_EN adds an acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_frame_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ*LEN_W-1:0]               req_len,
  input  logic [NUM_REQ*((1<<LEN_W)-1)-1:0]      req_data,
  input  logic                                   transmitted,
  output logic [NUM_REQ-1:0]                     grant,
  output logic                                   serOut,
  output logic                                   serOutValid,
  output logic                                   busy,
  output logic                                   timeout
);

  localparam int MAX_LEN = (1 << LEN_W) - 1;
  localparam int ID_W    = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_PORT     = 3'd2,
    S_COUNT    = 3'd3,
    S_DATA     = 3'd4,
    S_WAIT_ACK = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      last_q, last_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [MAX_LEN-1:0]   data_q, data_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 busy_q, busy_d;
  logic                 found;
  logic [ID_W-1:0]      sel;
  logic [ID_W-1:0]      cand;

`ifdef SERIAL_ARB_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    len_d     = len_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    grant_d   = '0;
    found     = 1'b0;
    sel       = '0;
    cand      = '0;
`ifdef SERIAL_ARB_ACK_TIMEOUT_EN
    timeout_d = 1'b0;
`endif

    // Search upward from the requester after the last one granted, wrapping.
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = last_q + ID_W'(i + 1);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_START;
          id_d         = sel;
          last_d       = sel;
          len_d        = req_len[sel*LEN_W +: LEN_W];
          data_d       = req_data[sel*MAX_LEN +: MAX_LEN];
          grant_d[sel] = 1'b1;
        end
      end
      S_START: begin
        state_d = S_PORT;
        cnt_d   = LEN_W'(ID_W - 1);
      end
      S_PORT: begin
        if (cnt_q == '0) begin
          state_d = S_COUNT;
          cnt_d   = LEN_W'(LEN_W - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_COUNT: begin
        if (cnt_q == '0) begin
          state_d = (len_q == '0) ? S_WAIT_ACK : S_DATA;
          cnt_d   = len_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_ACK: begin
        if (transmitted) begin
          state_d = S_IDLE;
        end
`ifdef SERIAL_ARB_ACK_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    case (state_d)
      S_START: ser_out_d = 1'b0;
      S_PORT:  ser_out_d = id_d[cnt_d[0]];
      S_COUNT: ser_out_d = len_d[cnt_d[1:0]];
      S_DATA:  ser_out_d = data_d[cnt_d];
      default: ser_out_d = 1'b1;
    endcase
    ser_valid_d = (state_d == S_START) || (state_d == S_PORT) ||
                  (state_d == S_COUNT) || (state_d == S_DATA);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      last_q      <= ID_W'(NUM_REQ - 1);
      len_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      grant_q     <= '0;
      ser_out_q   <= 1'b1;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      last_q      <= last_d;
      len_q       <= len_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SERIAL_ARB_ACK_TIMEOUT_EN
  always_comb begin
    tmo_d = '0;
    if (state_q == S_WAIT_ACK && state_d == S_WAIT_ACK) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  assign grant       = grant_q;
  assign serOut      = ser_out_q;
  assign serOutValid = ser_valid_q;
  assign busy        = busy_q;

endmodule

`default_nettype wire
